// File: rtl/host_cmd_bridge.sv
// Byte-stream command bridge: decodes host read/write commands and masters the
// register bus with single-cycle accesses, answering with data or ack/error bytes.
module host_cmd_bridge #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 6,
   parameter int NUM_REGS       = 63,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  bus_write_en,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic                  busy,
   output logic                  err,
   input  logic                  err_clr
);

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_DH, GET_DL, EXEC_WR, EXEC_RD,
      SEND_HI, SEND_LO, SEND_ACK, SEND_ERR
   } state_t;

   localparam int         CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

   state_t                state_q, state_d;
   logic                  is_wr_q, is_wr_d;
   logic                  addr_err_q, addr_err_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  err_set;
   logic                  rx_fire, tx_fire, in_get, addr_err_now;

   assign rx_ready = (state_q == IDLE) || in_get;
   assign tx_valid = (state_q == SEND_HI) || (state_q == SEND_LO) ||
                     (state_q == SEND_ACK) || (state_q == SEND_ERR);
   assign in_get   = (state_q == GET_ADDR) || (state_q == GET_DH) || (state_q == GET_DL);
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid && tx_ready;
   // Comparing the whole byte also rejects any nonzero bits above ADDR_WIDTH.
   assign addr_err_now = ({1'b0, rx_data} >= NUM_REGS_W);

   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign bus_write_en = (state_q == EXEC_WR);
   assign busy         = (state_q != IDLE);
   assign err          = err_q;

   always_comb begin
      tx_data = 8'h00;
      case (state_q)
         SEND_HI:  tx_data = rd_hold_q[15:8];
         SEND_LO:  tx_data = rd_hold_q[7:0];
         SEND_ACK: tx_data = 8'h4B;
         SEND_ERR: tx_data = 8'h45;
         default:  tx_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      is_wr_d     = is_wr_q;
      addr_err_d  = addr_err_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      rd_hold_d   = rd_hold_q;
      cnt_d       = '0;
      err_set     = 1'b0;

      case (state_q)
         IDLE: if (rx_fire) begin
            if (rx_data == 8'h57 || rx_data == 8'h52) begin
               is_wr_d = (rx_data == 8'h57);
               state_d = GET_ADDR;
            end else begin
               state_d = SEND_ERR;
               err_set = 1'b1;
            end
         end
         GET_ADDR: if (rx_fire) begin
            bus_addr_d = rx_data[ADDR_WIDTH-1:0];
            addr_err_d = addr_err_now;
            if (is_wr_q) begin
               state_d = GET_DH;
            end else if (addr_err_now) begin
               state_d = SEND_ERR;
               err_set = 1'b1;
            end else begin
               state_d = EXEC_RD;
            end
         end
         GET_DH: if (rx_fire) begin
            bus_wdata_d[15:8] = rx_data;
            state_d           = GET_DL;
         end
         GET_DL: if (rx_fire) begin
            bus_wdata_d[7:0] = rx_data;
            if (addr_err_q) begin
               state_d = SEND_ERR;
               err_set = 1'b1;
            end else begin
               state_d = EXEC_WR;
            end
         end
         EXEC_WR: state_d = SEND_ACK;
         EXEC_RD: begin
            rd_hold_d = bus_rdata;
            state_d   = SEND_HI;
         end
         SEND_HI: if (tx_fire) state_d = SEND_LO;
         SEND_LO, SEND_ACK, SEND_ERR: if (tx_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Inter-byte timeout: abandon the command silently.
      if (in_get && !rx_fire) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            err_set = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (err_set) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         is_wr_q     <= 1'b0;
         addr_err_q  <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         rd_hold_q   <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_wr_q     <= is_wr_d;
         addr_err_q  <= addr_err_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         rd_hold_q   <= rd_hold_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: doc/host_cmd_bridge.md
# host_cmd_bridge

Byte-stream command bridge that masters the Pak-DSP register bus (addr / write_en / wdata / rdata) of the memory map from a host link, e.g. a UART receiver/transmitter pair. It decodes read and write commands from incoming bytes and issues single-cycle register-bus accesses. It returns read data or acknowledge/error bytes on an outgoing byte stream. Both byte streams use valid/ready handshakes.

## Interface
- DATA_WIDTH, 16, register width; fixed at 16 (two data bytes, MSB first).
- ADDR_WIDTH, 6, register-bus address width.
- NUM_REGS, 63, number of implemented registers; addresses >= NUM_REGS are rejected.
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes of one command.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous reset, active-low
- rx_data  in  8  command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts byte; transfer when rx_valid & rx_ready at posedge
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts; transfer when tx_valid & tx_ready at posedge
- bus_addr  out  ADDR_WIDTH  register address
- bus_write_en  out  1  single-cycle write strobe
- bus_wdata  out  DATA_WIDTH  write data
- bus_rdata  in  DATA_WIDTH  read data, combinational from bus_addr while bus_write_en=0
- busy  out  1  high in every state except IDLE
- err  out  1  sticky error flag
- err_clr  in  1  synchronous clear of err

## Operation
- Write command: 0x57, addr byte, data hi, data lo. Response: 0x4B ('K') on success, 0x45 ('E') on error.
- Read command: 0x52, addr byte. Response: data hi, data lo on success, single 0x45 on error.
- Any other opcode: the opcode byte is consumed, 0x45 is sent, err is set.
- Address error: addr byte bits [7:ADDR_WIDTH] are nonzero, or addr >= NUM_REGS.
  - Write: both data bytes are still consumed, no bus write is issued, 0x45 is sent.
  - Read: no bus read, 0x45 is sent.
  - err is set in both cases.
- FSM states: IDLE, GET_ADDR, GET_DH, GET_DL, EXEC_WR, EXEC_RD, SEND_HI, SEND_LO, SEND_ACK, SEND_ERR.
  - IDLE: on accepted 0x57 or 0x52 go to GET_ADDR (opcode latched). On any other accepted byte go to SEND_ERR.
  - GET_ADDR: on accept, latch bus_addr = rx_data[ADDR_WIDTH-1:0] and latch the address-error flag.
    - Write opcode: go to GET_DH.
    - Read opcode: go to SEND_ERR if address error, else EXEC_RD.
  - GET_DH: on accept, latch bus_wdata[15:8], go to GET_DL.
  - GET_DL: on accept, latch bus_wdata[7:0]. Go to SEND_ERR if address error, else EXEC_WR.
  - EXEC_WR: one cycle, bus_write_en=1, then SEND_ACK.
  - EXEC_RD: one cycle, bus_write_en=0; bus_rdata captured into a holding register at the end of the cycle, then SEND_HI.
  - SEND_HI goes to SEND_LO on tx accept. SEND_LO, SEND_ACK and SEND_ERR go to IDLE on tx accept.
- rx_ready = 1 only in IDLE, GET_ADDR, GET_DH, GET_DL.
- tx_valid = 1 only in SEND_* states. tx_data is held stable while tx_valid & !tx_ready.
- Timeout: a counter runs in GET_ADDR/GET_DH/GET_DL and resets on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, set err, send no response, issue no bus access.
- err: set on any error or timeout. Cleared by err_clr. Set has priority over err_clr when both occur in the same cycle.
- bus_addr and bus_wdata hold their last latched values between commands. bus_write_en is never high outside EXEC_WR.
- Exactly one command is processed at a time. A new opcode is not accepted until the response byte(s) are transferred.

## Timing
- Reset values (asynchronous): state IDLE, rx_ready 1, tx_valid 0, tx_data 0x00, bus_addr 0, bus_wdata 0, bus_write_en 0, busy 0, err 0, timeout counter 0, read holding register 0.
- Write latency: last data byte accepted at edge N.
  - bus_write_en high for cycle N→N+1; the register updates at edge N+1.
  - tx_valid with 0x4B from edge N+1.
- Read latency: addr byte accepted at edge N.
  - EXEC_RD during cycle N→N+1; bus_rdata sampled at edge N+1.
  - tx_valid with data hi from edge N+1.
- Error response: tx_valid asserted the cycle after the offending byte is accepted.
- Reset mid-command: in-flight command is discarded, no bus write, outputs return to reset values immediately.
- Back-to-back: if tx_ready=1 continuously, a new opcode can be accepted the cycle after the final response byte transfers.

## Test plan
- Write then read: send 57 05 12 34; expect single bus_write_en pulse with addr 5, wdata 0x1234, then tx 4B. Send 52 05 with bus model returning 0x1234; expect tx 12, 34.
- Bad opcode and address range: send 41; expect tx 45 and err=1. Pulse err_clr; err=0. Send 57 3F AA BB (NUM_REGS=63); expect no write strobe and tx 45. Send 52 80; expect tx 45.
- tx backpressure: read addr 0 (rdata 0xBEEF) with tx_ready low for 5 cycles; expect tx_data=BE held stable, then BE, EF in order after release; rx_ready=0 throughout.
- Timeout: TIMEOUT_CYCLES=16; send 57 02 then stall; expect return to IDLE after 16 cycles, err=1, no tx, no write. Next 52 02 is processed normally.
- Reset mid-command: assert arst_n low after 57 07 AB accepted; expect all outputs at reset values and no write. Next 57 07 00 01 writes 0x0001.
- rx_valid gaps and back-to-back commands: random idle cycles inserted between bytes (below timeout) over 100 random read/write commands; responses match a scoreboard of the register model.
